mem_req_ctrl: RTL and testbench
===============================

MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 SHALL take widths from params.vh: W (data and address width), M (depth, words).
REQ-002 clk  in  1  single clock, all state on posedge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req_a_valid / req_a_ready  in / out  1  client A request handshake.
REQ-005 req_a_we  in  1  1 = write, 0 = read.
REQ-006 req_a_addr / req_a_wdata  in  W  client A address and write data.
REQ-007 rsp_a_valid  out  1  client A read data valid.
REQ-008 rsp_a_data  out  W  client A read data.
REQ-009 Client B SHALL have identical ports: req_b_valid, req_b_ready, req_b_we, req_b_addr, req_b_wdata, rsp_b_valid, rsp_b_data.
REQ-010 ram_data_x / ram_addr_x  out  W  RAM port x write data and address.
REQ-011 ram_we_x  out  1  RAM port x write enable.
REQ-012 ram_q_x  in  W  RAM port x registered read data.
REQ-013 Port y SHALL mirror port x: ram_data_y, ram_addr_y, ram_we_y, ram_q_y.
REQ-014 busy  out  1  initialisation sweep in progress.

Function
REQ-015 Client A SHALL map to RAM port x; client B SHALL map to RAM port y.
REQ-016 The FSM SHALL have two states, INIT and RUN; requests SHALL be accepted only in RUN.
REQ-017 A request SHALL be accepted on a posedge where valid and ready are both 1; address, data and we SHALL drive the RAM port combinationally in that same cycle.
REQ-018 req_a_ready SHALL equal (state == RUN).
REQ-019 conflict SHALL be defined as: both valid, addresses equal, and at least one we = 1.
REQ-020 req_b_ready SHALL equal (state == RUN) && !conflict; on conflict A is served first and B is accepted no earlier than the next cycle.
REQ-021 Two reads to the same address in one cycle SHALL both be accepted.
REQ-022 ram_we_x/y SHALL be 1 only for an accepted write or an INIT sweep write; they SHALL be driven 0/1, never Z.
REQ-023 An accepted read at edge N SHALL raise rsp_valid for exactly the cycle after edge N, with rsp_data = ram_q of that port (1-cycle latency).
REQ-024 rsp_valid SHALL be 0 after accepted writes and in idle cycles; rsp_data is don't-care while rsp_valid = 0.
REQ-025 Back-to-back reads SHALL be accepted every cycle, giving one response per cycle.
REQ-026 A read accepted after a conflicting write to the same address SHALL return the newly written data.

Reset
REQ-027 While rst_n = 0: rsp_a_valid = rsp_b_valid = 0, ram_we_x = ram_we_y = 0, the sweep counter = 0, and busy reflects REQ-030.
REQ-028 Reset asserted mid-operation SHALL drop in-flight reads with no response and restart from the post-reset state.
REQ-029 RAM contents SHALL NOT be altered by reset itself.

Configuration
REQ-030 With MEM_REQ_INIT_EN defined: reset SHALL enter INIT, and busy SHALL be 1 throughout INIT.
REQ-031 INIT sweep: each cycle, port x SHALL write 0 to address 2k and port y SHALL write 0 to address 2k+1, for k = 0 .. ceil(M/2)-1.
REQ-032 If M is odd, the final port y write SHALL be suppressed.
REQ-033 After the last sweep cycle the FSM SHALL go to RUN and busy SHALL go 0.
REQ-034 Without MEM_REQ_INIT_EN: reset SHALL go directly to RUN, busy SHALL be tied to 0, and no sweep logic is built.

Verification
REQ-035 INIT_EN, M = 16, release rst_n -> busy = 1 for 8 cycles; ram_we_x/y = 1 with addresses (0,1) .. (14,15), data 0; then req_a_ready = 1.
REQ-036 A writes addr 5 data 0xA5, next cycle A reads addr 5 -> rsp_a_valid = 1 exactly one cycle after read accept, rsp_a_data = 0xA5.
REQ-037 Same cycle: A writes addr 3 data 0x3C, B reads addr 3 -> req_b_ready = 0 that cycle; B accepted next cycle; rsp_b_data = 0x3C.
REQ-038 Same cycle: A and B both read addr 7 -> both ready = 1; both rsp_valid = 1 next cycle with equal data.
REQ-039 A read accepted, rst_n = 0 on the next cycle -> rsp_a_valid stays 0 and all outputs hold their reset values.
REQ-040 Without INIT_EN: release rst_n -> busy = 0 and req_a_ready = 1 in the first cycle.

Source files
------------

// File: rtl/mem_req_ctrl.sv
// -----------------------------------------------------------------------------
// mem_req_ctrl
//
// Two-client front end for a dual-port RAM with registered read data.
// Client A owns RAM port x and client B owns RAM port y. The RAM is driven
// combinationally in the accept cycle. Read data comes back one cycle later,
// straight from the RAM's registered q output.
//
// When both clients target the same address and at least one of them writes,
// B is held off for that cycle. A is served first, so a B read issued after
// an A write to the same address sees the new data.
//
// Optional feature: define MEM_REQ_INIT_EN to build a zero-fill sweep after
// reset. Port x clears the even addresses and port y clears the odd ones,
// two words per cycle. busy is high for the whole sweep. Without the macro
// the controller comes out of reset ready, busy is tied low, and no sweep
// logic is built.
//
// Parameters
//   W  data and address width
//   M  RAM depth in words
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_a_* / rsp_a_*           client A request handshake and read response
//   req_b_* / rsp_b_*           client B request handshake and read response
//   ram_{addr,data,we}_x / _y   RAM port drive
//   ram_q_x / ram_q_y           RAM registered read data
//   busy                        initialisation sweep in progress
// -----------------------------------------------------------------------------
module mem_req_ctrl #(
  parameter int W = 8,
  parameter int M = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_a_valid,
  output logic         req_a_ready,
  input  logic         req_a_we,
  input  logic [W-1:0] req_a_addr,
  input  logic [W-1:0] req_a_wdata,
  output logic         rsp_a_valid,
  output logic [W-1:0] rsp_a_data,
  input  logic         req_b_valid,
  output logic         req_b_ready,
  input  logic         req_b_we,
  input  logic [W-1:0] req_b_addr,
  input  logic [W-1:0] req_b_wdata,
  output logic         rsp_b_valid,
  output logic [W-1:0] rsp_b_data,
  output logic [W-1:0] ram_data_x,
  output logic [W-1:0] ram_addr_x,
  output logic         ram_we_x,
  input  logic [W-1:0] ram_q_x,
  output logic [W-1:0] ram_data_y,
  output logic [W-1:0] ram_addr_y,
  output logic         ram_we_y,
  input  logic [W-1:0] ram_q_y,
  output logic         busy
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_run;
  logic   w_conflict;
  logic   w_acc_a;
  logic   w_acc_b;
  logic   r_rsp_a_vld;
  logic   r_rsp_b_vld;

`ifdef MEM_REQ_INIT_EN
  localparam int NSWEEP = (M + 1) / 2;
  localparam int CW     = (NSWEEP > 1) ? $clog2(NSWEEP) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_last;
  logic [W-1:0]  w_sw_addr_x;
  logic [W-1:0]  w_sw_addr_y;
  logic          w_sw_we_y;

  assign w_last      = (r_cnt == CW'(NSWEEP - 1));
  assign w_sw_addr_x = W'({r_cnt, 1'b0});
  assign w_sw_addr_y = W'({r_cnt, 1'b1});
  // With an odd depth the last odd address would be past the end of the RAM.
  assign w_sw_we_y   = !((M % 2 == 1) && w_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == S_INIT && !w_last) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign busy = (r_state == S_INIT);
`else
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef MEM_REQ_INIT_EN
      r_state <= S_INIT;
`else
      r_state <= S_RUN;
`endif
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
`ifdef MEM_REQ_INIT_EN
    if (r_state == S_INIT && w_last) begin
      w_state_nxt = S_RUN;
    end
`endif
  end

  assign w_run      = (r_state == S_RUN);
  assign w_conflict = req_a_valid && req_b_valid && (req_a_addr == req_b_addr) &&
                      (req_a_we || req_b_we);
  assign req_a_ready = w_run;
  assign req_b_ready = w_run && !w_conflict;
  assign w_acc_a     = req_a_valid && req_a_ready;
  assign w_acc_b     = req_b_valid && req_b_ready;

  // RAM port drive: the clients by default, the sweep while initialising.
  always_comb begin
    ram_addr_x = req_a_addr;
    ram_data_x = req_a_wdata;
    ram_we_x   = w_acc_a && req_a_we;
    ram_addr_y = req_b_addr;
    ram_data_y = req_b_wdata;
    ram_we_y   = w_acc_b && req_b_we;
`ifdef MEM_REQ_INIT_EN
    if (r_state == S_INIT) begin
      ram_addr_x = w_sw_addr_x;
      ram_data_x = '0;
      ram_we_x   = 1'b1;
      ram_addr_y = w_sw_addr_y;
      ram_data_y = '0;
      ram_we_y   = w_sw_we_y;
    end
`endif
    // Reset must never disturb RAM contents, so the write strobes are
    // blocked for as long as rst_n is low, whatever the state register holds.
    if (!rst_n) begin
      ram_we_x = 1'b0;
      ram_we_y = 1'b0;
    end
  end

  // Read response: one cycle after accept, data taken from the RAM's q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_a_vld <= 1'b0;
      r_rsp_b_vld <= 1'b0;
    end else begin
      r_rsp_a_vld <= w_acc_a && !req_a_we;
      r_rsp_b_vld <= w_acc_b && !req_b_we;
    end
  end

  assign rsp_a_valid = r_rsp_a_vld;
  assign rsp_b_valid = r_rsp_b_vld;
  assign rsp_a_data  = ram_q_x;
  assign rsp_b_data  = ram_q_y;

endmodule

// File: tb/tb_mem_req_ctrl.sv
module tb_mem_req_ctrl;
  localparam int W = 8;
  localparam int M = 16;
`ifdef MEM_REQ_INIT_EN
  localparam int NS = (M + 1) / 2;
`else
  localparam int NS = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_a_valid, req_a_ready, req_a_we;
  logic [W-1:0] req_a_addr, req_a_wdata;
  logic         rsp_a_valid;
  logic [W-1:0] rsp_a_data;
  logic         req_b_valid, req_b_ready, req_b_we;
  logic [W-1:0] req_b_addr, req_b_wdata;
  logic         rsp_b_valid;
  logic [W-1:0] rsp_b_data;
  logic [W-1:0] ram_data_x, ram_addr_x, ram_q_x;
  logic [W-1:0] ram_data_y, ram_addr_y, ram_q_y;
  logic         ram_we_x, ram_we_y, busy;

  always #5 clk = ~clk;

  mem_req_ctrl #(.W(W), .M(M)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a_valid(req_a_valid), .req_a_ready(req_a_ready), .req_a_we(req_a_we),
    .req_a_addr(req_a_addr), .req_a_wdata(req_a_wdata),
    .rsp_a_valid(rsp_a_valid), .rsp_a_data(rsp_a_data),
    .req_b_valid(req_b_valid), .req_b_ready(req_b_ready), .req_b_we(req_b_we),
    .req_b_addr(req_b_addr), .req_b_wdata(req_b_wdata),
    .rsp_b_valid(rsp_b_valid), .rsp_b_data(rsp_b_data),
    .ram_data_x(ram_data_x), .ram_addr_x(ram_addr_x), .ram_we_x(ram_we_x), .ram_q_x(ram_q_x),
    .ram_data_y(ram_data_y), .ram_addr_y(ram_addr_y), .ram_we_y(ram_we_y), .ram_q_y(ram_q_y),
    .busy(busy)
  );

  // Dual-port RAM with registered read data (old data on simultaneous write).
  logic [W-1:0] ram [M];
  always_ff @(posedge clk) begin
    if (ram_we_x) ram[ram_addr_x % M] <= ram_data_x;
    if (ram_we_y) ram[ram_addr_y % M] <= ram_data_y;
    ram_q_x <= ram[ram_addr_x % M];
    ram_q_y <= ram[ram_addr_y % M];
  end

  typedef struct {
    int           due;
    logic [W-1:0] data;
  } rsp_t;

  rsp_t         qa[$];
  rsp_t         qb[$];
  logic [W-1:0] exp_mem [M];
  int           cyc  = 0;
  int           tick = 0;
  int           nchk = 0;
  int           nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic conflict_now();
    return req_a_valid && req_b_valid && (req_a_addr == req_b_addr) && (req_a_we || req_b_we);
  endfunction

  // Reference model: counts cycles since reset release, tracks memory
  // contents by address and queues the read responses each client is owed.
  initial begin
    forever begin
      @(posedge clk);
      tick++;
      if (!rst_n) begin
        cyc = 0;
        qa.delete();
        qb.delete();
      end else begin
        if (cyc < NS) begin
          exp_mem[(2 * cyc) % M] = '0;
          if (2 * cyc + 1 < M) exp_mem[2 * cyc + 1] = '0;
        end else begin
          logic acc_b;
          acc_b = req_b_valid && !conflict_now();
          // Same-cycle accepts never alias a write, so reads see the old contents.
          if (req_a_valid && !req_a_we) qa.push_back('{tick, exp_mem[req_a_addr % M]});
          if (acc_b && !req_b_we) qb.push_back('{tick, exp_mem[req_b_addr % M]});
          if (req_a_valid && req_a_we) exp_mem[req_a_addr % M] = req_a_wdata;
          if (acc_b && req_b_we) exp_mem[req_b_addr % M] = req_b_wdata;
        end
        cyc++;
      end
    end
  end

  // Monitor: samples on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_rsp_a_valid", 32'(rsp_a_valid), 0);
        chk("rst_rsp_b_valid", 32'(rsp_b_valid), 0);
        chk("rst_ram_we_x", 32'(ram_we_x), 0);
        chk("rst_ram_we_y", 32'(ram_we_y), 0);
        chk("rst_busy", 32'(busy), 32'(NS > 0));
      end else begin
        logic run;
        run = (cyc >= NS);
        chk("busy", 32'(busy), 32'(!run));
        chk("req_a_ready", 32'(req_a_ready), 32'(run));
        chk("req_b_ready", 32'(req_b_ready), 32'(run && !conflict_now()));
        if (!run) begin
          chk("sweep_we_x", 32'(ram_we_x), 1);
          chk("sweep_addr_x", 32'(ram_addr_x), 32'(2 * cyc));
          chk("sweep_data_x", 32'(ram_data_x), 0);
          chk("sweep_we_y", 32'(ram_we_y), 32'(2 * cyc + 1 < M));
          if (2 * cyc + 1 < M) begin
            chk("sweep_addr_y", 32'(ram_addr_y), 32'(2 * cyc + 1));
            chk("sweep_data_y", 32'(ram_data_y), 0);
          end
        end else begin
          logic wa, wb;
          wa = req_a_valid && req_a_we;
          wb = req_b_valid && req_b_we && !conflict_now();
          chk("ram_we_x", 32'(ram_we_x), 32'(wa));
          chk("ram_we_y", 32'(ram_we_y), 32'(wb));
          if (wa) begin
            chk("ram_addr_x", 32'(ram_addr_x), 32'(req_a_addr));
            chk("ram_data_x", 32'(ram_data_x), 32'(req_a_wdata));
          end
          if (wb) begin
            chk("ram_addr_y", 32'(ram_addr_y), 32'(req_b_addr));
            chk("ram_data_y", 32'(ram_data_y), 32'(req_b_wdata));
          end
        end
        if (rsp_a_valid) begin
          if (qa.size() == 0) chk("rsp_a_unexpected", 1, 0);
          else begin
            rsp_t e;
            e = qa.pop_front();
            chk("rsp_a_latency", 32'(tick), 32'(e.due));
            chk("rsp_a_data", 32'(rsp_a_data), 32'(e.data));
          end
        end
        if (rsp_b_valid) begin
          if (qb.size() == 0) chk("rsp_b_unexpected", 1, 0);
          else begin
            rsp_t e;
            e = qb.pop_front();
            chk("rsp_b_latency", 32'(tick), 32'(e.due));
            chk("rsp_b_data", 32'(rsp_b_data), 32'(e.data));
          end
        end
        // A response owed this cycle that did not appear.
        if (qa.size() > 0 && qa[0].due <= tick) begin
          chk("rsp_a_missing", 0, 1);
          void'(qa.pop_front());
        end
        if (qb.size() > 0 && qb[0].due <= tick) begin
          chk("rsp_b_missing", 0, 1);
          void'(qb.pop_front());
        end
      end
    end
  end

  task automatic drv(input logic av, input logic awe, input logic [W-1:0] aad, input logic [W-1:0] awd,
                     input logic bv, input logic bwe, input logic [W-1:0] bad, input logic [W-1:0] bwd);
    req_a_valid = av; req_a_we = awe; req_a_addr = aad; req_a_wdata = awd;
    req_b_valid = bv; req_b_we = bwe; req_b_addr = bad; req_b_wdata = bwd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++)
      drv(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom_range(0, 7)), W'($urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom_range(0, 7)), W'($urandom));
  endtask

  initial begin
    for (int i = 0; i < M; i++) begin
      ram[i]     = W'($urandom);
      exp_mem[i] = ram[i];
    end
    rst_n = 1'b0;
    req_a_valid = 0; req_a_we = 0; req_a_addr = '0; req_a_wdata = '0;
    req_b_valid = 0; req_b_we = 0; req_b_addr = '0; req_b_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(NS + 1);

    // A writes then reads addr 5
    drv(1, 1, 8'd5, 8'hA5, 0, 0, '0, '0);
    drv(1, 0, 8'd5, '0, 0, 0, '0, '0);
    idle(1);
    // A write / B read conflict on addr 3, B retried next cycle
    drv(1, 1, 8'd3, 8'h3C, 1, 0, 8'd3, '0);
    drv(0, 0, '0, '0, 1, 0, 8'd3, '0);
    idle(1);
    // A read / B write conflict on addr 6, then B proceeds
    drv(1, 0, 8'd6, '0, 1, 1, 8'd6, 8'h66);
    drv(0, 0, '0, '0, 1, 1, 8'd6, 8'h66);
    drv(1, 0, 8'd6, '0, 0, 0, '0, '0);
    // Both read addr 7 in the same cycle
    drv(1, 0, 8'd7, '0, 1, 0, 8'd7, '0);
    // Back-to-back reads on both ports
    for (int i = 0; i < 6; i++) drv(1, 0, W'(i), '0, 1, 0, W'(7 - i), '0);
    idle(2);
    rand_cycles(300);
    idle(2);

    // Read accepted, then reset before the response cycle completes
    drv(1, 0, 8'd7, '0, 1, 0, 8'd2, '0);
    rst_n = 1'b0;
    req_a_valid = 0; req_b_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(NS + 1);
    rand_cycles(150);
    idle(3);

    chk("qa_drained", 32'(qa.size()), 0);
    chk("qb_drained", 32'(qb.size()), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
